// File: rtl/frame_text_display.sv
`default_nettype none
// ============================================================================
//  Module   : frame_text_display
//  Purpose  : 40x30 character frame buffer scanned out as a 640x480@60 VGA
//             raster using 16x16 glyphs from an external font ROM.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_text_display #(
    parameter logic [23:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR   = 24'h000000,
    parameter logic [5:0]  CLEAR_CODE = 6'd10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  frame_char,
    input  logic [5:0]  frame_x,
    input  logic [5:0]  frame_y,
    input  logic        frame_we,
    input  logic        frame_clear,
    output logic        clear_busy,
    output logic [9:0]  font_addr,
    input  logic [15:0] font_q,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_clk
);

    localparam int unsigned CELLS    = 1200;
    localparam int unsigned COLS     = 40;
    localparam int unsigned ROWS     = 30;
    localparam logic [9:0]  H_VIS    = 10'd640;
    localparam logic [9:0]  H_LAST   = 10'd799;
    localparam logic [9:0]  HS_START = 10'd656;
    localparam logic [9:0]  HS_END   = 10'd751;
    localparam logic [9:0]  V_VIS    = 10'd480;
    localparam logic [9:0]  V_LAST   = 10'd524;
    localparam logic [9:0]  VS_START = 10'd490;
    localparam logic [9:0]  VS_END   = 10'd491;

    // ------------------------------------------------------------------
    // Clear sweep controller. ST_START is the reset state so that a sweep
    // begins on the first clock after reset is released.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SWEEP = 2'd2
    } clr_state_t;

    clr_state_t  state_q, state_d;
    logic [10:0] clr_addr_q, clr_addr_d;

    // Sweep state and address registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_START;
            clr_addr_q <= 11'd0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Sweep next-state: one cell per clock, clear pulses while busy ignored
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_START: begin
                state_d    = ST_SWEEP;
                clr_addr_d = 11'd0;
            end
            ST_IDLE: begin
                if (frame_clear) begin
                    state_d    = ST_SWEEP;
                    clr_addr_d = 11'd0;
                end
            end
            ST_SWEEP: begin
                if (clr_addr_q == 11'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 11'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clear_busy = (state_q == ST_SWEEP);

    // ------------------------------------------------------------------
    // Character RAM write port: the sweep owns the port while busy.
    // ------------------------------------------------------------------
    logic        ext_in_range;
    logic [10:0] ext_addr;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [5:0]  wr_data;

    // Write address and arbitration between sweep and external writes
    always_comb begin
        ext_in_range = (frame_x < 6'(COLS)) && (frame_y < 6'(ROWS));
        ext_addr     = ({5'd0, frame_y} << 5) + ({5'd0, frame_y} << 3) + {5'd0, frame_x};
        wr_en        = 1'b0;
        wr_addr      = ext_addr;
        wr_data      = frame_char;
        if (clear_busy) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr_q;
            wr_data = CLEAR_CODE;
        end else if (frame_we && ext_in_range) begin
            wr_en = 1'b1;
        end
    end

    logic [5:0] char_mem [0:CELLS-1];

    // Character RAM storage (contents are defined by the post-reset sweep)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            char_mem[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Raster counters and scan pipeline
    // ------------------------------------------------------------------
    logic        pix_en_q;
    logic [9:0]  hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        vis_now, hs_now, vs_now;
    logic [10:0] rd_addr;

    // Next counter values and the S0 read address for the current pixel
    always_comb begin
        hcnt_d  = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d  = vcnt_q;
        if (hcnt_q == H_LAST) begin
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
        vis_now = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
        hs_now  = !((hcnt_q >= HS_START) && (hcnt_q <= HS_END));
        vs_now  = !((vcnt_q >= VS_START) && (vcnt_q <= VS_END));
        rd_addr = 11'd0;
        if (vis_now) begin
            rd_addr = ({6'd0, vcnt_q[8:4]} << 5) + ({6'd0, vcnt_q[8:4]} << 3)
                    + {5'd0, hcnt_q[9:4]};
        end
    end

    logic [5:0]  code_q;
    logic [3:0]  hlo_p1_q, vlo_p1_q, hlo_p2_q;
    logic        vis_p1_q, hs_p1_q, vs_p1_q;
    logic        vis_p2_q, hs_p2_q, vs_p2_q;
    logic [15:0] glyph_q;
    logic [23:0] rgb_q;
    logic        hs_q, vs_q, blank_n_q;

    // Pixel-rate counters plus the S1..S3 stages; sync/visible ride alongside
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en_q  <= 1'b0;
            hcnt_q    <= 10'd0;
            vcnt_q    <= 10'd0;
            code_q    <= 6'd0;
            hlo_p1_q  <= 4'd0;
            vlo_p1_q  <= 4'd0;
            hlo_p2_q  <= 4'd0;
            vis_p1_q  <= 1'b0;
            hs_p1_q   <= 1'b1;
            vs_p1_q   <= 1'b1;
            vis_p2_q  <= 1'b0;
            hs_p2_q   <= 1'b1;
            vs_p2_q   <= 1'b1;
            glyph_q   <= 16'd0;
            rgb_q     <= 24'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            pix_en_q <= ~pix_en_q;
            if (pix_en_q) begin
                hcnt_q    <= hcnt_d;
                vcnt_q    <= vcnt_d;
                code_q    <= char_mem[rd_addr];
                hlo_p1_q  <= hcnt_q[3:0];
                vlo_p1_q  <= vcnt_q[3:0];
                vis_p1_q  <= vis_now;
                hs_p1_q   <= hs_now;
                vs_p1_q   <= vs_now;
                hlo_p2_q  <= hlo_p1_q;
                vis_p2_q  <= vis_p1_q;
                hs_p2_q   <= hs_p1_q;
                vs_p2_q   <= vs_p1_q;
                glyph_q   <= font_q;
                if (vis_p2_q) begin
                    rgb_q <= glyph_q[4'd15 - hlo_p2_q] ? FG_COLOR : BG_COLOR;
                end else begin
                    rgb_q <= 24'd0;
                end
                hs_q      <= hs_p2_q;
                vs_q      <= vs_p2_q;
                blank_n_q <= vis_p2_q;
            end
        end
    end

    // The ROM address is formed from S1 registers so the ROM's one-clock
    // latency resolves well inside the two-clock pixel period.
    assign font_addr   = {code_q, vlo_p1_q};
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_clk     = pix_en_q;

endmodule
`default_nettype wire

// File: doc/frame_text_display.md
# frame_text_display

Read side of the character frame buffer that the cycle printer writes into. It holds a 40×30 grid of 6-bit character codes written through the `frame_*` port and scans them out continuously as a 640×480@60 VGA raster. Each code is a 16×16 glyph fetched from an external font ROM. The block sits between the print logic and the board VGA DAC.

## Interface
- `FG_COLOR`, default 24'hFFFFFF: RGB for glyph-on pixels.
- `BG_COLOR`, default 24'h000000: RGB for glyph-off pixels.
- `CLEAR_CODE`, default 6'd10: code written by a clear sweep (blank glyph).
- `clk` input, 1 bit: 50 MHz system clock, the only clock.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `frame_char` input, 6 bits: character code to write.
- `frame_x` input, 6 bits: column, valid range 0–39.
- `frame_y` input, 6 bits: row, valid range 0–29.
- `frame_we` input, 1 bit: write strobe, sampled on every `clk`.
- `frame_clear` input, 1 bit: single-cycle pulse that starts a clear sweep.
- `clear_busy` output, 1 bit: high while a sweep runs.
- `font_addr` output, 10 bits: font ROM address, {code[5:0], glyph row[3:0]}.
- `font_q` input, 16 bits: font ROM data. It arrives 1 `clk` after `font_addr`; bit 15 is the leftmost pixel.
- `vga_r`, `vga_g`, `vga_b` output, 8 bits each: pixel color.
- `vga_hs`, `vga_vs` output, 1 bit each: syncs, active-low.
- `vga_blank_n` output, 1 bit: high during the visible area.
- `vga_clk` output, 1 bit: pixel clock, `clk`/2.

## Operation
- **Character RAM:** 1200 entries × 6 bits.
  - Address = y*40 + x, computed as (y<<5)+(y<<3)+x, 11 bits.
  - A write with x ≥ 40 or y ≥ 30 is dropped. No wrap, no aliasing.
- **Write port:** not throttled; one write per `clk` is accepted.
- **Clear sweep:**
  - While `clear_busy`=1, external writes are dropped.
  - The sweep writes `CLEAR_CODE` to addresses 0..1199 in order, one per `clk`.
  - `frame_clear` pulsed while busy is ignored; the sweep does not restart.
- **Pixel enable:** `pix_en` toggles every `clk`, starting at 0 after reset. `vga_clk` = `pix_en`. All raster logic advances only on `pix_en`=1.
- **Raster counters:**
  - `hcnt` runs 0..799 and wraps to 0; `vcnt` increments when `hcnt` wraps and runs 0..524, wrapping to 0.
  - Visible area: `hcnt` < 640 and `vcnt` < 480.
  - `hs` is low for `hcnt` 656..751; `vs` is low for `vcnt` 490..491.
- **Scan pipeline** (each stage is one pixel period):
  - S0: char RAM read address = (vcnt[8:4])*40 + hcnt[9:4]. The address is forced to 0 when outside the visible area.
  - S1: code available; drive `font_addr` = {code, vcnt_d1[3:0]}.
  - S2: `font_q` valid. Pixel = `font_q`[15 − hcnt_d2[3:0]].
  - S3: registered outputs. RGB is the FG or BG color when visible; RGB = 0 when blanked.
- **Sync alignment:** `hs`, `vs` and visible are delayed 3 pixel periods so they align with RGB.
- **Read-during-write:** a write to the cell being scanned may return the old or the new code for that pixel. Either result is acceptable; no corruption is allowed.

## Timing
- **Reset (`reset_n` low, asynchronous):**
  - `hcnt`, `vcnt` and `pix_en` = 0; pipeline registers are cleared.
  - `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, RGB=0, `vga_clk`=0, `font_addr`=0.
- **After reset release:** `clear_busy` = 1 from the first rising `clk` and lasts exactly 1200 `clk`. A clear sweep starts automatically, so RAM contents are known.
- **Reset mid-sweep:** the sweep aborts and then restarts from address 0 when reset releases.
- **`frame_clear` pulse while idle:** `clear_busy` rises on the next `clk` and falls after 1200 `clk`.
- **Write-to-display latency:** a write becomes visible at the next scan of that cell; there is no other latency.
- **Pixel latency:** counter value to pin is 3 pixel periods (6 `clk`).
- **Frame period:** 800×525 pixel periods = 840000 `clk`.

## Test plan
- **Reset and auto-clear:** deassert `reset_n`, hold `frame_we`=1 at (0,0) code 5. Expect `clear_busy`=1 for exactly 1200 `clk`, the write dropped, and cell (0,0) = 10 (checked through `font_addr` = {6'd10, row}).
- **Sync timing:** run 2 frames. Expect `vga_hs` low for 96 pixels per line, period 800; `vga_vs` low for 2 lines, period 525; `vga_blank_n` high for 640×480 per frame.
- **Write and scan:** write code 37 at (39,29). When scanning pixel (624..639, 464..479), expect `font_addr`[9:4] = 37; with `font_q` = 16'h8000, only the pixel at hcnt=624 is FG, appearing exactly 3 pixel periods later.
- **Out-of-range write:** write (40,0) code 7 and (0,30) code 7. Expect no cell changed; (0,1) and (0,0) still read code 10.
- **Clear and write interaction:** write (5,5) code 3, then pulse `frame_clear`. During busy, write (6,6) code 4 and pulse `frame_clear` again. Expect a single 1200-cycle busy period, both cells = 10, (6,6) ≠ 4.
- **Async reset mid-frame:** assert `reset_n` low at vcnt=200. Expect outputs at their reset values immediately without waiting for `clk`; after release, a new frame starts at hcnt=vcnt=0.
